// File: rtl/tdc_pkg.sv
// Shared constants, timestamp bundle and FSM states
// for the CARRY4 TDC thermometer encoder.
package tdc_pkg;

    localparam int NCARRY4  = 46;
    localparam int NTAPS    = 4 * NCARRY4;
    localparam int FINE_W   = 8;
    localparam int COARSE_W = 24;

    typedef struct packed {
        logic [COARSE_W-1:0] coarse;
        logic [FINE_W-1:0]   fine;
        logic                ovf;
    } ts_t;

    typedef enum logic [1:0] {
        DISARMED   = 2'd0,
        ARMED      = 2'd1,
        HOLDOFF    = 2'd2,
        WAIT_CLEAR = 2'd3
    } tdc_state_t;

    function automatic logic [2:0] cell_ones(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/tdc_popcount_pipe.sv
// Two-stage ones-count of the sampled line: per-cell counts,
// then the full sum; side data rides along with the valid bit.
module tdc_popcount_pipe #(
    parameter int NCARRY4 = 46,
    parameter int FINE_W  = 8,
    parameter int SIDE_W  = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic [4*NCARRY4-1:0] i_taps,
    input  logic [SIDE_W-1:0]    i_side,
    output logic                 o_valid,
    output logic [FINE_W-1:0]    o_sum,
    output logic                 o_ovf,
    output logic [SIDE_W-1:0]    o_side
);
    import tdc_pkg::*;

    localparam int NT = 4 * NCARRY4;

    logic [2:0]        r_cnt [NCARRY4];
    logic              r_va;
    logic [SIDE_W-1:0] r_side_a;
    logic              r_vb;
    logic [FINE_W-1:0] r_sum;
    logic              r_ovf;
    logic [SIDE_W-1:0] r_side_b;
    logic [FINE_W-1:0] w_sum;

    // Stage A: per-CARRY4 ones counts plus sideband
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCARRY4; i++)
                r_cnt[i] <= '0;
            r_va     <= 1'b0;
            r_side_a <= '0;
        end else begin
            for (int i = 0; i < NCARRY4; i++)
                r_cnt[i] <= cell_ones(i_taps[4*i +: 4]);
            r_va     <= i_valid;
            r_side_a <= i_side;
        end
    end

    // Adder tree over the registered cell counts
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NCARRY4; i++)
            w_sum = w_sum + FINE_W'(r_cnt[i]);
    end

    // Stage B: results update only for a valid hit and then hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vb     <= 1'b0;
            r_sum    <= '0;
            r_ovf    <= 1'b0;
            r_side_b <= '0;
        end else begin
            r_vb <= r_va;
            if (r_va) begin
                r_sum    <= w_sum;
                r_ovf    <= (w_sum == FINE_W'(NT));
                r_side_b <= r_side_a;
            end
        end
    end

    assign o_valid = r_vb;
    assign o_sum   = r_sum;
    assign o_ovf   = r_ovf;
    assign o_side  = r_side_b;

endmodule

// File: rtl/tdc_thermo_encoder.sv
// Start-hit detector and timestamp encoder behind the
// CARRY4 delay line: sync, FSM, drop count, fine/coarse pairing.
module tdc_thermo_encoder #(
    parameter int NCARRY4     = tdc_pkg::NCARRY4,
    parameter int FINE_W      = tdc_pkg::FINE_W,
    parameter int COARSE_W    = tdc_pkg::COARSE_W,
    parameter int HOLDOFF_CYC = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [4*NCARRY4-1:0] co,
    output logic                 ts_valid,
    output logic [FINE_W-1:0]    ts_fine,
    output logic [COARSE_W-1:0]  ts_coarse,
    output logic                 ts_ovf,
    output logic [15:0]          drop_cnt,
    output logic                 busy
);
    import tdc_pkg::*;

    localparam int NT = 4 * NCARRY4;

    logic [NT-1:0]       r_s1;
    logic [NT-1:0]       r_s2;
    logic                r_p0;
    logic [COARSE_W-1:0] r_coarse;
    tdc_state_t          r_state;
    tdc_state_t          w_state_nxt;
    logic [7:0]          r_hold;
    logic [7:0]          w_hold_nxt;
    logic [15:0]         r_drop;
    logic                w_hit;
    logic                w_accept;
    logic                w_drop_inc;
    logic                w_pv;
    logic [FINE_W-1:0]   w_psum;
    logic                w_povf;
    logic [COARSE_W-1:0] w_pcoarse;
    ts_t                 w_ts;

    // Two-flop capture of the line plus the previous tap-0 sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_p0 <= 1'b0;
        end else begin
            r_s1 <= co;
            r_s2 <= r_s1;
            r_p0 <= r_s2[0];
        end
    end

    assign w_hit    = r_s2[0] & ~r_p0;
    assign w_accept = w_hit & (r_state == ARMED);

    // Free-running coarse time base
    always_ff @(posedge clk) begin
        if (rst)
            r_coarse <= '0;
        else
            r_coarse <= r_coarse + COARSE_W'(1);
    end

    // FSM state and holdoff counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DISARMED;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // Next state; disable overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        unique case (r_state)
            DISARMED: begin
                w_state_nxt = r_s2[0] ? WAIT_CLEAR : ARMED;
            end
            ARMED: begin
                if (w_hit) begin
                    w_state_nxt = HOLDOFF;
                    w_hold_nxt  = 8'(HOLDOFF_CYC - 1);
                end
            end
            HOLDOFF: begin
                if (r_hold == 8'd0)
                    w_state_nxt = WAIT_CLEAR;
                else
                    w_hold_nxt = r_hold - 8'd1;
            end
            WAIT_CLEAR: begin
                if (!r_s2[0])
                    w_state_nxt = ARMED;
            end
        endcase
        if (!enable)
            w_state_nxt = DISARMED;
    end

    assign busy = (r_state == HOLDOFF) |
                  (r_state == WAIT_CLEAR);

    assign w_drop_inc = w_hit & busy &
                        (r_drop != 16'hFFFF);

    // Saturating count of hits landing in dead time
    always_ff @(posedge clk) begin
        if (rst)
            r_drop <= '0;
        else if (w_drop_inc)
            r_drop <= r_drop + 16'd1;
    end

    assign drop_cnt = r_drop;

    tdc_popcount_pipe #(
        .NCARRY4 (NCARRY4),
        .FINE_W  (FINE_W),
        .SIDE_W  (COARSE_W)
    ) u_pop (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_accept),
        .i_taps  (r_s2),
        .i_side  (r_coarse),
        .o_valid (w_pv),
        .o_sum   (w_psum),
        .o_ovf   (w_povf),
        .o_side  (w_pcoarse)
    );

    assign w_ts.coarse = w_pcoarse;
    assign w_ts.fine   = w_psum;
    assign w_ts.ovf    = w_povf;

    assign ts_valid  = w_pv;
    assign ts_fine   = w_ts.fine;
    assign ts_coarse = w_ts.coarse;
    assign ts_ovf    = w_ts.ovf;

endmodule
